display_mux_driver: RTL

//  Output-side reader of the RPN calculator datapath. Latches the value, flags and

---
 rtl/display_mux_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/display_mux_driver.sv
// display_mux_driver: latches calculator output and scans it onto an 8-digit common-anode 7-seg display; define DEC_MODE_EN for decimal conversion
module display_mux_driver #(
  parameter logic [15:0] COUNT_MAX = 16'd50000,
  parameter int          N_DIGITS  = 8
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                Load,
  input  logic [15:0]         Value,
  input  logic [3:0]          Flags,
  input  logic [2:0]          Status,
  output logic                Busy,
  output logic [6:0]          Segments,
  output logic                DP,
  output logic [N_DIGITS-1:0] Anodes
);
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [19:0] disp_val;
  logic [3:0]  disp_flags;
  logic [2:0]  disp_status;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  font;
  // refresh divider: one digit slot per COUNT_MAX cycles
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == COUNT_MAX - 16'd1) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else
      cnt <= cnt + 16'd1;
  assign nib = idx == 3'd7 ? {1'b0, disp_status} :
               idx == 3'd6 ? disp_flags :
               idx == 3'd4 ? disp_val[19:16] : disp_val[{idx[1:0], 2'b00} +: 4];
`ifdef DEC_MODE_EN
  assign blank = idx == 3'd5;
`else
  assign blank = idx == 3'd5 || idx == 3'd4;
`endif
  // active-low hex font, bit 0 = segment a
  always_comb begin
    font = 7'h7F;
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
    endcase
  end
  // registered pin drivers so the anode and segment pattern switch together
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      Anodes   <= '1;
      Segments <= 7'h7F;
      DP       <= 1'b1;
    end else begin
      Anodes   <= ~(N_DIGITS'(1) << idx);
      Segments <= blank ? 7'h7F : font;
      DP       <= idx != 3'd6;
    end
`ifdef DEC_MODE_EN
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2;
  logic [1:0]  state;
  logic [15:0] work_val, pend_val;
  logic [3:0]  work_flags, pend_flags, it;
  logic [2:0]  work_status, pend_status;
  logic [19:0] bcd, adj;
  logic        pending;
  assign Busy = state != IDLE;
  // double-dabble correction: add 3 to every BCD nibble that would overflow on shift
  always_comb
    for (int i = 0; i < 5; i++)
      adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  // conversion FSM; display regs only change at COMMIT so no partial value is shown
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state       <= IDLE;
      work_val    <= '0;
      work_flags  <= '0;
      work_status <= '0;
      pend_val    <= '0;
      pend_flags  <= '0;
      pend_status <= '0;
      pending     <= 1'b0;
      bcd         <= '0;
      it          <= '0;
      disp_val    <= '0;
      disp_flags  <= '0;
      disp_status <= '0;
    end else
      case (state)
        IDLE:
          if (Load) begin
            state       <= SHIFT;
            work_val    <= Value;
            work_flags  <= Flags;
            work_status <= Status;
            bcd         <= '0;
            it          <= '0;
          end
        SHIFT: begin
          bcd      <= {adj[18:0], work_val[15]};
          work_val <= {work_val[14:0], 1'b0};
          it       <= it + 4'd1;
          if (it == 4'd15) state <= COMMIT;
          if (Load) begin
            pend_val    <= Value;
            pend_flags  <= Flags;
            pend_status <= Status;
            pending     <= 1'b1;
          end
        end
        default: begin
          disp_val    <= bcd;
          disp_flags  <= work_flags;
          disp_status <= work_status;
          bcd         <= '0;
          it          <= '0;
          pending     <= 1'b0;
          if (Load || pending) begin
            state       <= SHIFT;
            work_val    <= Load ? Value : pend_val;
            work_flags  <= Load ? Flags : pend_flags;
            work_status <= Load ? Status : pend_status;
          end else
            state <= IDLE;
        end
      endcase
`else
  assign Busy = 1'b0;
  // direct capture of the presented value as hex digits
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      disp_val    <= '0;
      disp_flags  <= '0;
      disp_status <= '0;
    end else if (Load) begin
      disp_val    <= {4'h0, Value};
      disp_flags  <= Flags;
      disp_status <= Status;
    end
`endif
endmodule
